// File: rtl/aes_kat_pkg.sv
// Shared types and constants for the AES known-answer-test sequencer.
// Build option: AES_KAT_STOP_ON_FAIL_EN (see aes_kat_sequencer).
package aes_kat_pkg;

  localparam int AES_BLK_W = 128;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    CHECK,
    FINISH
  } state_t;

endpackage

// File: rtl/aes_kat_timeout.sv
// Saturating wait counter; expire flags the last allowed cycle.
// Used by aes_kat_sequencer while waiting on the cipher core.
module aes_kat_timeout #(
  parameter int TIMEOUT_CYC = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable && cnt != LAST) begin
      cnt <= cnt + TW'(1);
    end
  end

  assign expire = enable && (cnt == LAST);

endmodule

// File: rtl/aes_kat_sequencer.sv
// Runs NUM_VEC known-answer vectors through an AES core and reports status.
// Define AES_KAT_STOP_ON_FAIL_EN to stop at the first failing vector.
module aes_kat_sequencer
  import aes_kat_pkg::*;
#(
  parameter int NUM_VEC     = 4,
  parameter int LD_CYC      = 2,
  parameter int TIMEOUT_CYC = 32,
  localparam int AW = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1,
  localparam int CW = $clog2(NUM_VEC + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [AW-1:0]        vec_addr,
  input  logic [AES_BLK_W-1:0] vec_key,
  input  logic [AES_BLK_W-1:0] vec_text,
  input  logic [AES_BLK_W-1:0] vec_exp,
  output logic                 core_ld,
  output logic [AES_BLK_W-1:0] core_key,
  output logic [AES_BLK_W-1:0] core_text_in,
  input  logic                 core_done,
  input  logic [AES_BLK_W-1:0] core_cypher,
  output logic                 busy,
  output logic                 pass,
  output logic                 fail,
  output logic                 timeout,
  output logic [CW-1:0]        err_count
);

  localparam logic [AW-1:0] LAST    = AW'(NUM_VEC - 1);
  localparam logic [3:0]    LD_LAST = 4'(LD_CYC - 1);
  localparam logic [CW-1:0] EMAX    = CW'(NUM_VEC);

  state_t               state, state_n;
  logic [AW-1:0]        idx;
  logic [3:0]           ld_cnt;
  logic [AES_BLK_W-1:0] exp_q, cap_q;
  logic                 tmo_q, tmo_hit;
  logic                 miss, stop, expire;
  logic [CW-1:0]        err_n;

  aes_kat_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_tmo (
    .clk   (clk),
    .rst   (rst),
    .clear (state != WAIT),
    .enable(state == WAIT),
    .expire(expire)
  );

  // vec_addr looks one step ahead so the store output is valid
  // on the very edge that enters LOAD.
  always_comb begin
    state_n  = state;
    vec_addr = idx;
    tmo_hit  = 1'b0;
    miss     = 1'b0;
    stop     = 1'b0;
    err_n    = err_count;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n  = LOAD;
          vec_addr = '0;
        end
      end
      LOAD: begin
        if (ld_cnt == LD_LAST) state_n = WAIT;
      end
      WAIT: begin
        if (core_done || expire) begin
          state_n = CHECK;
          tmo_hit = !core_done;
        end
      end
      CHECK: begin
        miss = tmo_q || (cap_q != exp_q);
        stop = (idx == LAST);
`ifdef AES_KAT_STOP_ON_FAIL_EN
        stop = stop || miss;
`endif
        state_n = stop ? FINISH : LOAD;
        if (!stop) vec_addr = idx + AW'(1);
      end
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // a timed-out vector is counted once, at expiry
    if ((tmo_hit || (state == CHECK && miss && !tmo_q)) &&
        err_count != EMAX) begin
      err_n = err_count + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      ld_cnt       <= '0;
      core_ld      <= 1'b0;
      core_key     <= '0;
      core_text_in <= '0;
      exp_q        <= '0;
      cap_q        <= '0;
      tmo_q        <= 1'b0;
      err_count    <= '0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state     <= state_n;
      err_count <= err_n;
      core_ld   <= (state_n == LOAD);
      if (state_n == LOAD && state != LOAD) begin
        idx          <= vec_addr;
        core_key     <= vec_key;
        core_text_in <= vec_text;
        exp_q        <= vec_exp;
        ld_cnt       <= '0;
        tmo_q        <= 1'b0;
      end else if (state == LOAD) begin
        ld_cnt <= ld_cnt + 4'd1;
      end
      if (state == IDLE && start) begin
        err_count <= '0;
        pass      <= 1'b0;
        fail      <= 1'b0;
        timeout   <= 1'b0;
      end
      if (state == WAIT && state_n == CHECK) begin
        cap_q <= core_cypher;
        tmo_q <= tmo_hit;
      end
      if (tmo_hit) timeout <= 1'b1;
      if (state_n == FINISH) begin
        pass <= (err_n == '0);
        fail <= (err_n != '0);
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_aes_kat_sequencer.sv
// Directed bench for aes_kat_sequencer with a behavioural cipher core.
// Honours AES_KAT_STOP_ON_FAIL_EN for its expected values.
module tb_aes_kat_sequencer;

  localparam int NV = 4;
  localparam logic [127:0] KAT0 = 128'h3f5b8cc9ea855a0afa7347d23e8d664e;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [1:0]   vec_addr;
  logic [127:0] vec_key, vec_text, vec_exp;
  logic         core_ld, core_done;
  logic [127:0] core_key, core_text_in, core_cypher;
  logic         busy, pass, fail, timeout;
  logic [2:0]   err_count;

  always #5 clk = ~clk;

  aes_kat_sequencer #(
    .NUM_VEC(NV), .LD_CYC(2), .TIMEOUT_CYC(32)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .vec_addr(vec_addr), .vec_key(vec_key),
    .vec_text(vec_text), .vec_exp(vec_exp),
    .core_ld(core_ld), .core_key(core_key),
    .core_text_in(core_text_in), .core_done(core_done),
    .core_cypher(core_cypher), .busy(busy), .pass(pass),
    .fail(fail), .timeout(timeout), .err_count(err_count)
  );

  function automatic logic [127:0] fake_aes(input logic [127:0] k,
                                            input logic [127:0] t);
    if (k == '0 && t == '1) return KAT0;
    return k ^ {t[63:0], t[127:64]} ^ 128'ha5a5_0000_ffff_1234_5678_9abc_def0_0f0f;
  endfunction

  logic [127:0] vkey [NV];
  logic [127:0] vtxt [NV];
  logic [127:0] vexp [NV];
  assign vec_key  = vkey[vec_addr];
  assign vec_text = vtxt[vec_addr];
  assign vec_exp  = vexp[vec_addr];

  // core model: done pulses in WAIT cycle wait_lat (0 = never)
  int           wait_lat;
  int           wcnt  = 0;
  logic         armed = 1'b0;
  logic [127:0] kl = '0, tl = '0;
  int           loads = 0, ldcyc = 0;
  logic         ld_prev = 1'b0;

  always @(posedge clk) begin
    if (core_ld) begin
      kl    <= core_key;
      tl    <= core_text_in;
      wcnt  <= 0;
      armed <= 1'b1;
      ldcyc <= ldcyc + 1;
      if (!ld_prev) loads <= loads + 1;
    end else begin
      wcnt <= wcnt + 1;
    end
    ld_prev <= core_ld;
  end

  assign core_done   = armed && wait_lat > 0 && wcnt == wait_lat - 1;
  assign core_cypher = fake_aes(kl, tl);

  int npass = 0, ntot = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic chkw(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // returns busy cycles counted from the first LOAD cycle
  task automatic run(input string tag, input bit mid, output int cyc);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_ld0"}, 32'(core_ld), 32'd1);
    chkw({tag, "_key0"}, core_key, vkey[0]);
    cyc = 0;
    while (busy && cyc < 1000) begin
      cyc++;
      start = mid && cyc == 5;
      tick();
      start = 1'b0;
    end
    chk({tag, "_done_in_time"}, 32'(busy), 32'd0);
  endtask

  int cyc, l0, c0;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    wait_lat = 3;
    vkey[0] = '0;
    vtxt[0] = '1;
    vkey[1] = 128'h000102030405060708090a0b0c0d0e0f;
    vtxt[1] = 128'h00112233445566778899aabbccddeeff;
    vkey[2] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    vtxt[2] = 128'h6bc1bee22e409f96e93d7e117393172a;
    vkey[3] = 128'hffffffffffffffff0000000000000000;
    vtxt[3] = 128'h0123456789abcdeffedcba9876543210;
    for (int i = 0; i < NV; i++) vexp[i] = fake_aes(vkey[i], vtxt[i]);

    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_fail", 32'(fail), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    chk("rst_ld", 32'(core_ld), 32'd0);
    chk("rst_addr", 32'(vec_addr), 32'd0);
    chkw("rst_key", core_key, '0);
    chkw("rst_text", core_text_in, '0);
    rst = 1'b0;
    tick();

    // all vectors good, vector 0 is the real AES KAT
    l0 = loads;
    c0 = ldcyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    chkw("kat_text0", core_text_in, '1);
    chk("kat_busy", 32'(busy), 32'd1);
    cyc = 1;
    while (busy && cyc < 1000) begin
      tick();
      if (busy) cyc++;
    end
    chk("kat_cycles", 32'(cyc), 32'd25);
    chk("kat_pass", 32'(pass), 32'd1);
    chk("kat_fail", 32'(fail), 32'd0);
    chk("kat_err", 32'(err_count), 32'd0);
    chk("kat_loads", 32'(loads - l0), 32'd4);
    chk("kat_ldcyc", 32'(ldcyc - c0), 32'd8);
    repeat (3) tick();
    chk("kat_pass_hold", 32'(pass), 32'd1);

    // vector 2 expected value corrupted, with a stray start mid-run
    vexp[2][0] = ~vexp[2][0];
    l0 = loads;
    run("bad2", 1'b1, cyc);
    chk("bad2_fail", 32'(fail), 32'd1);
    chk("bad2_pass", 32'(pass), 32'd0);
    chk("bad2_err", 32'(err_count), 32'd1);
`ifdef AES_KAT_STOP_ON_FAIL_EN
    chk("bad2_loads", 32'(loads - l0), 32'd3);
    chk("bad2_addr", 32'(vec_addr), 32'd2);
    chk("bad2_cycles", 32'(cyc), 32'd19);
`else
    chk("bad2_loads", 32'(loads - l0), 32'd4);
    chk("bad2_cycles", 32'(cyc), 32'd25);
`endif
    vexp[2][0] = ~vexp[2][0];

    // core never finishes
    wait_lat = 0;
    l0 = loads;
    run("tmo", 1'b0, cyc);
    chk("tmo_flag", 32'(timeout), 32'd1);
    chk("tmo_fail", 32'(fail), 32'd1);
`ifdef AES_KAT_STOP_ON_FAIL_EN
    chk("tmo_err", 32'(err_count), 32'd1);
    chk("tmo_cycles", 32'(cyc), 32'd36);
    chk("tmo_loads", 32'(loads - l0), 32'd1);
`else
    chk("tmo_err", 32'(err_count), 32'd4);
    chk("tmo_cycles", 32'(cyc), 32'd141);
    chk("tmo_loads", 32'(loads - l0), 32'd4);
`endif

    // reset in the WAIT of vector 1, then a clean run
    wait_lat = 10;
    l0 = loads;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!(loads - l0 == 2 && !core_ld) && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("mid_reached_wait1", 32'(loads - l0), 32'd2);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_addr", 32'(vec_addr), 32'd0);
    chk("mid_timeout", 32'(timeout), 32'd0);
    chk("mid_fail", 32'(fail), 32'd0);
    chk("mid_ld", 32'(core_ld), 32'd0);
    rst = 1'b0;
    wait_lat = 3;
    tick();
    run("rerun", 1'b0, cyc);
    chk("rerun_pass", 32'(pass), 32'd1);
    chk("rerun_err", 32'(err_count), 32'd0);
    chk("rerun_cycles", 32'(cyc), 32'd25);

    // done arrives on the exact expiry cycle
    wait_lat = 32;
    run("edge", 1'b0, cyc);
    chk("edge_timeout", 32'(timeout), 32'd0);
    chk("edge_pass", 32'(pass), 32'd1);
    chk("edge_err", 32'(err_count), 32'd0);
    chk("edge_cycles", 32'(cyc), 32'd141);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
